// File: rtl/shift_pkg.sv
// +----------------------------------------------------------------------------+
// | shift_pkg : funct encodings, issue states and the shift-command record     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

package shift_pkg;

  localparam logic [5:0] FUNCT_SLL  = 6'b000000;
  localparam logic [5:0] FUNCT_SRL  = 6'b000010;
  localparam logic [5:0] FUNCT_SRA  = 6'b000011;
  localparam logic [5:0] FUNCT_SLLV = 6'b000100;
  localparam logic [5:0] FUNCT_SRLV = 6'b000110;
  localparam logic [5:0] FUNCT_SRAV = 6'b000111;

  // Widest destination index a command can carry; narrower RD_W zero-pads.
  localparam int RD_W_MAX = 16;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } issue_state_e;

  typedef struct packed {
    logic [31:0]         d;
    logic [4:0]          sa;
    logic                right;
    logic                arith;
    logic [RD_W_MAX-1:0] rd;
    logic                illegal;
  } shift_cmd_t;

endpackage

`default_nettype wire

// File: rtl/shift_issue_if.sv
// +----------------------------------------------------------------------------+
// | shift_issue_if : instruction-in / shift-command-out bundle                 |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

interface shift_issue_if #(
  parameter int RD_W = 5
);
  logic            in_valid;
  logic            in_ready;
  logic [5:0]      in_funct;
  logic [4:0]      in_shamt;
  logic [31:0]     in_rs;
  logic [31:0]     in_rt;
  logic [RD_W-1:0] in_rd;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [31:0]     sh_d;
  logic [4:0]      sh_sa;
  logic            sh_right;
  logic            sh_arith;
  logic [RD_W-1:0] out_rd;
  logic            out_illegal;

  modport master (
    output in_valid, in_funct, in_shamt, in_rs, in_rt, in_rd, flush, out_ready,
    input  in_ready, out_valid, sh_d, sh_sa, sh_right, sh_arith, out_rd, out_illegal
  );

  modport slave (
    input  in_valid, in_funct, in_shamt, in_rs, in_rt, in_rd, flush, out_ready,
    output in_ready, out_valid, sh_d, sh_sa, sh_right, sh_arith, out_rd, out_illegal
  );
endinterface

`default_nettype wire

// File: rtl/shift_decode.sv
// +----------------------------------------------------------------------------+
// | shift_decode : R-type funct/shamt/rs -> shift command (combinational)      |
// | Config macro: SHIFT_VAR_EN enables sllv/srlv/srav.        Rev 1.0          |
// +----------------------------------------------------------------------------+
`default_nettype none

module shift_decode
  import shift_pkg::*;
#(
  parameter int RD_W = 5
) (
  input  logic [5:0]      funct,
  input  logic [4:0]      shamt,
  input  logic [31:0]     rs,
  input  logic [31:0]     rt,
  input  logic [RD_W-1:0] rd,
  output shift_cmd_t      cmd
);

  // Only rs[4:0] can ever matter; without variable shifts rs is dead entirely.
  logic unused_rs;
`ifdef SHIFT_VAR_EN
  assign unused_rs = ^rs[31:5];
`else
  assign unused_rs = ^rs;
`endif

  always_comb begin
    cmd    = '0;
    cmd.d  = rt;
    cmd.rd = RD_W_MAX'(rd);
    case (funct)
      FUNCT_SLL, FUNCT_SRL, FUNCT_SRA: begin
        cmd.sa    = shamt;
        cmd.right = funct[1];
        cmd.arith = funct[1] & funct[0];
      end
`ifdef SHIFT_VAR_EN
      FUNCT_SLLV, FUNCT_SRLV, FUNCT_SRAV: begin
        cmd.sa    = rs[4:0];
        cmd.right = funct[1];
        cmd.arith = funct[1] & funct[0];
      end
`endif
      default: cmd.illegal = 1'b1;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/shift_issue.sv
// +----------------------------------------------------------------------------+
// | shift_issue : decode + two-entry skid buffer issuing shift commands        |
// | Config macro: SHIFT_VAR_EN (see shift_decode).            Rev 1.0          |
// +----------------------------------------------------------------------------+
`default_nettype none

module shift_issue
  import shift_pkg::*;
#(
  parameter int RD_W = 5
) (
  input logic          clk,
  input logic          rst,
  shift_issue_if.slave bus
);

  shift_cmd_t   dec_cmd;
  shift_cmd_t   main_d, main_q;
  shift_cmd_t   skid_d, skid_q;
  issue_state_e state_d, state_q;
  logic         out_valid_d, out_valid_q;
  logic         in_ready_d, in_ready_q;
  logic         accept, drain;

  shift_decode #(.RD_W(RD_W)) u_decode (
    .funct (bus.in_funct),
    .shamt (bus.in_shamt),
    .rs    (bus.in_rs),
    .rt    (bus.in_rt),
    .rd    (bus.in_rd),
    .cmd   (dec_cmd)
  );

  assign accept = bus.in_valid & in_ready_q;
  assign drain  = out_valid_q & bus.out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (bus.flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            main_d  = dec_cmd;
            state_d = ST_ONE;
          end
        end
        ST_ONE: begin
          if (accept && drain) begin
            main_d = dec_cmd;
          end else if (accept) begin
            skid_d  = dec_cmd;
            state_d = ST_FULL;
          end else if (drain) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          // in_ready is low here, so only the head can move.
          if (drain) begin
            main_d  = skid_q;
            state_d = ST_ONE;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
    out_valid_d = (state_d != ST_EMPTY);
    in_ready_d  = (state_d != ST_FULL);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.sh_d        = main_q.d;
  assign bus.sh_sa       = main_q.sa;
  assign bus.sh_right    = main_q.right;
  assign bus.sh_arith    = main_q.arith;
  assign bus.out_rd      = main_q.rd[RD_W-1:0];
  assign bus.out_illegal = main_q.illegal;

  generate
    if (RD_W < RD_W_MAX) begin : g_rd_pad
      logic unused_rd_hi;
      assign unused_rd_hi = ^main_q.rd[RD_W_MAX-1:RD_W];
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_shift_issue.sv
// +----------------------------------------------------------------------------+
// | tb_shift_issue : queue-model bench for shift_issue                         |
// | Honours SHIFT_VAR_EN like the design.                     Rev 1.0          |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_shift_issue;

  typedef struct packed {
    logic [31:0] d;
    logic [4:0]  sa;
    logic        right;
    logic        arith;
    logic [4:0]  rd;
    logic        illegal;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  shift_issue_if #(.RD_W(5)) bus ();

  shift_issue #(.RD_W(5)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int   total = 0;
  int   bad   = 0;
  exp_t q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t actual();
    return {bus.sh_d, bus.sh_sa, bus.sh_right, bus.sh_arith, bus.out_rd, bus.out_illegal};
  endfunction

  // Reference decode written from the instruction semantics.
  function automatic exp_t model_cmd(input logic [5:0] f, input logic [4:0] sh,
                                     input logic [31:0] rs, input logic [31:0] rt,
                                     input logic [4:0] rd);
    exp_t e;
    bit   fixed, var_ok;
    e       = '0;
    e.d     = rt;
    e.rd    = rd;
    fixed   = (f == 6'd0 || f == 6'd2 || f == 6'd3);
`ifdef SHIFT_VAR_EN
    var_ok  = (f == 6'd4 || f == 6'd6 || f == 6'd7);
`else
    var_ok  = 1'b0;
`endif
    if (!(fixed || var_ok)) begin
      e.illegal = 1'b1;
    end else begin
      e.sa    = fixed ? sh : 5'(rs % 32);
      e.right = (f == 6'd2 || f == 6'd3 || f == 6'd6 || f == 6'd7);
      e.arith = (f == 6'd3 || f == 6'd7);
    end
    return e;
  endfunction

  // Model: FIFO of at most two commands; head is what the outputs show.
  always @(posedge clk or posedge rst) begin
    int n;
    if (rst || bus.flush) begin
      q.delete();
    end else begin
      n = q.size();
      if (bus.in_valid && n < 2)
        q.push_back(model_cmd(bus.in_funct, bus.in_shamt, bus.in_rs, bus.in_rt, bus.in_rd));
      if (n > 0 && bus.out_ready)
        void'(q.pop_front());
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      check("in_ready", 64'(bus.in_ready), 64'(q.size() < 2));
      check("out_valid", 64'(bus.out_valid), 64'(q.size() > 0));
      if (q.size() > 0)
        check("cmd", 64'(actual()), 64'(q[0]));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [5:0] f, input logic [4:0] sh, input logic [31:0] rs,
                       input logic [31:0] rt, input logic [4:0] rd);
    bus.in_valid = 1'b1;
    bus.in_funct = f;
    bus.in_shamt = sh;
    bus.in_rs    = rs;
    bus.in_rt    = rt;
    bus.in_rd    = rd;
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] ftab [6];
    ftab = '{6'd0, 6'd2, 6'd3, 6'd4, 6'd6, 6'd7};
    bus.in_valid  = 1'b0;
    bus.in_funct  = '0;
    bus.in_shamt  = '0;
    bus.in_rs     = '0;
    bus.in_rt     = '0;
    bus.in_rd     = '0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;

    // Reset state
    repeat (2) tick();
    check("rst_valid", 64'(bus.out_valid), 64'd0);
    check("rst_ready", 64'(bus.in_ready), 64'd1);
    check("rst_cmd", 64'(actual()), 64'd0);
    rst = 1'b0;

    // sra, accepted on the first edge after reset release
    bus.out_ready = 1'b1;
    offer(6'b000011, 5'd4, 32'd0, 32'h8000_0000, 5'd5);
    tick();
    idle();
    check("sra_valid", 64'(bus.out_valid), 64'd1);
    check("sra_cmd", 64'(actual()), 64'({32'h8000_0000, 5'd4, 1'b1, 1'b1, 5'd5, 1'b0}));
    tick();
    check("sra_drained", 64'(bus.out_valid), 64'd0);

    // srlv with rs above 31
    offer(6'b000110, 5'd0, 32'h0000_0023, 32'hF000_0000, 5'd9);
    tick();
    idle();
`ifdef SHIFT_VAR_EN
    check("srlv_cmd", 64'(actual()), 64'({32'hF000_0000, 5'd3, 1'b1, 1'b0, 5'd9, 1'b0}));
`else
    check("srlv_cmd", 64'(actual()), 64'({32'hF000_0000, 5'd0, 1'b0, 1'b0, 5'd9, 1'b1}));
`endif
    tick();

    // Illegal funct
    offer(6'b100000, 5'd7, 32'h1234_5678, 32'hCAFE_F00D, 5'd17);
    tick();
    idle();
    check("ill_cmd", 64'(actual()), 64'({32'hCAFE_F00D, 5'd0, 1'b0, 1'b0, 5'd17, 1'b1}));
    tick();
    check("ill_done", 64'(bus.out_valid), 64'd0);

    // Backpressure: three offers, two accepted, released in order
    bus.out_ready = 1'b0;
    offer(6'd0, 5'd1, 32'd0, 32'h1111_1111, 5'd1);
    tick();
    check("bp_a_ready", 64'(bus.in_ready), 64'd1);
    offer(6'd0, 5'd1, 32'd0, 32'h2222_2222, 5'd2);
    tick();
    check("bp_full_ready", 64'(bus.in_ready), 64'd0);
    check("bp_hold_a1", 64'(bus.sh_d), 64'h1111_1111);
    offer(6'd0, 5'd1, 32'd0, 32'h3333_3333, 5'd3);
    tick();
    check("bp_hold_a2", 64'(bus.sh_d), 64'h1111_1111);
    idle();
    bus.out_ready = 1'b1;
    tick();
    check("bp_b", 64'({bus.out_valid, bus.sh_d}), 64'({1'b1, 32'h2222_2222}));
    tick();
    check("bp_no_c", 64'(bus.out_valid), 64'd0);

    // Flush while full, with a simultaneous offer
    bus.out_ready = 1'b0;
    offer(6'd2, 5'd3, 32'd0, 32'hAAAA_0001, 5'd4);
    tick();
    offer(6'd2, 5'd3, 32'd0, 32'hAAAA_0002, 5'd4);
    tick();
    bus.flush = 1'b1;
    offer(6'd2, 5'd3, 32'd0, 32'hAAAA_0003, 5'd4);
    tick();
    bus.flush = 1'b0;
    idle();
    check("fl_full", 64'({bus.out_valid, bus.in_ready}), 64'({1'b0, 1'b1}));
    tick();
    check("fl_full_after", 64'(bus.out_valid), 64'd0);

    // Flush overrides an accept while one entry is held
    offer(6'd0, 5'd2, 32'd0, 32'hBBBB_0001, 5'd6);
    tick();
    bus.flush = 1'b1;
    offer(6'd0, 5'd2, 32'd0, 32'hBBBB_0002, 5'd6);
    tick();
    bus.flush = 1'b0;
    idle();
    check("fl_one", 64'(bus.out_valid), 64'd0);

    // Asynchronous reset mid-stream
    offer(6'd3, 5'd9, 32'd0, 32'hDEAD_BEEF, 5'd31);
    tick();
    idle();
    check("ar_pre", 64'(bus.out_valid), 64'd1);
    #2 rst = 1'b1;
    #1;
    check("ar_valid", 64'({bus.out_valid, bus.in_ready}), 64'({1'b0, 1'b1}));
    check("ar_cmd", 64'(actual()), 64'd0);
    tick();
    rst = 1'b0;

    // Randomised traffic against the queue model
    for (int i = 0; i < 3000; i++) begin
      logic [5:0]  f;
      logic [31:0] rs;
      f  = ($urandom % 8 < 6) ? ftab[$urandom % 6] : 6'($urandom);
      rs = ($urandom % 4 == 0) ? 32'd32 : $urandom;
      bus.in_valid  = ($urandom % 4) != 0;
      bus.in_funct  = f;
      bus.in_shamt  = 5'($urandom);
      bus.in_rs     = rs;
      bus.in_rt     = $urandom;
      bus.in_rd     = 5'($urandom);
      bus.out_ready = ($urandom % 3) != 0;
      bus.flush     = ($urandom % 20) == 0;
      tick();
    end
    idle();
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;
    repeat (4) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/shift_issue.md
SHIFT_ISSUE -- requirements
Module: shift_issue

Interface
REQ-001 Parameter RD_W, default 5, destination-register index width.
REQ-002 clk  input  1  sole clock, rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 in_valid  input  1  upstream offers a decoded R-type instruction.
REQ-005 in_ready  output  1  stage can accept this cycle.
REQ-006 in_funct  input  6  R-type funct field.
REQ-007 in_shamt  input  5  instruction shamt field.
REQ-008 in_rs  input  32  rs operand value.
REQ-009 in_rt  input  32  rt operand value, the data to be shifted.
REQ-010 in_rd  input  RD_W  destination index.
REQ-011 flush  input  1  synchronous kill of all held entries.
REQ-012 out_valid  output  1  registered shift command is available.
REQ-013 out_ready  input  1  shifter/writeback consumes the command.
REQ-014 sh_d  output  32  operand to shifter d.
REQ-015 sh_sa  output  5  shift amount to shifter sa.
REQ-016 sh_right  output  1  1 = right shift.
REQ-017 sh_arith  output  1  1 = arithmetic right shift.
REQ-018 out_rd  output  RD_W  destination index.
REQ-019 out_illegal  output  1  funct is not a supported shift; writeback suppressed downstream.

Function
REQ-020 Decode: 000000 sll, 000010 srl, 000011 sra shall use sa=in_shamt; 000100 sllv, 000110 srlv, 000111 srav shall use sa=in_rs[4:0].
REQ-021 right=funct[1]; arith=funct[1]&funct[0]; sh_d=in_rt for every supported funct.
REQ-022 Unsupported funct: entry accepted, out_illegal=1, sh_sa=0, sh_right=0, sh_arith=0, sh_d=in_rt.
REQ-023 Transfer occurs on in_valid&in_ready (input side) and out_valid&out_ready (output side).
REQ-024 Storage: main register plus one skid register; in_ready = !skid_valid, registered, with no combinational path from out_ready.
REQ-025 Latency: accepted entry appears on outputs the next cycle when main is empty or draining.
REQ-026 States EMPTY (no entry), ONE (main only), FULL (main+skid); EMPTY->ONE on accept; ONE->ONE on accept+drain; ONE->FULL on accept without drain; FULL->ONE on drain, skid moves to main; ONE->EMPTY on drain without accept.
REQ-027 In FULL, in_ready=0; no entry is ever dropped or duplicated; order is preserved.
REQ-028 Outputs shall be stable while out_valid=1 and out_ready=0.
REQ-029 flush shall clear both entries next edge (state EMPTY) and override a simultaneous accept.
REQ-030 sa is 5 bits; rs[31:5] shall be ignored (shift by 32 rs=32 gives sa=0).

Reset
REQ-031 rst asserted shall immediately force EMPTY: out_valid=0, in_ready=1, sh_d=0, sh_sa=0, sh_right=0, sh_arith=0, out_rd=0, out_illegal=0.
REQ-032 Reset mid-transfer shall discard in-flight entries; first accept allowed on the first edge after rst deasserts.

Configuration
REQ-033 Macro SHIFT_VAR_EN: defined -> sllv/srlv/srav decoded per REQ-020.
REQ-034 SHIFT_VAR_EN undefined -> functs 000100/000110/000111 treated as unsupported per REQ-022; rs unused.

Structure
REQ-035 Shared package shift_pkg holds funct constants (FUNCT_SLL ... FUNCT_SRAV) and a shift-command struct typedef {d, sa, right, arith, rd, illegal}.
REQ-036 One sub-module shift_decode: combinational funct/shamt/rs -> command; shift_issue holds the skid registers and control.

Verification
REQ-037 sra: funct=000011, shamt=4, rt=0x80000000 -> next cycle out_valid=1, sh_sa=4, right=1, arith=1, sh_d=0x80000000.
REQ-038 srlv: funct=000110, rs=0x00000023, rt=0xF0000000 -> sh_sa=3, right=1, arith=0 (with SHIFT_VAR_EN); without it out_illegal=1.
REQ-039 Backpressure: out_ready=0, three back-to-back offers -> two accepted, in_ready=0 after second, outputs hold first; release -> entries emerge in order.
REQ-040 flush in FULL with in_valid=1 -> next cycle out_valid=0, in_ready=1, offered entry not captured.
REQ-041 Illegal funct=100000 -> out_illegal=1, sh_sa=0, handshake completes normally.
REQ-042 rst asserted mid-stream with out_valid=1 -> out_valid drops before next clock edge; all outputs zero.
